audio_stream_router: RTL and testbench

Parametrised successor to the fixed 4-input stereo output mux in the audio pipeline. It selects one of `NUM_SRC` multi-channel PCM sources and assembles the per-channel valid strobes into complete frames. Frames are buffered in a small FIFO and handed to the output serializer / VU driver over a valid/ready handshake. It adds frame alignment, back-pressure, overflow accounting, glitch-free source switching and mute, none of which the current mux has.

---
 rtl/audio_router_pkg.sv | 11 +
 rtl/audio_frame_fifo.sv | 47 ++++
 rtl/audio_stream_router.sv | 125 ++++++++++++
 tb/tb_audio_stream_router.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/audio_router_pkg.sv
// audio_router_pkg: shared state type, default parameters and peak-meter constants
package audio_router_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, COLLECT} state_e;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int PEAK_W = 8;
  localparam int DECAY_PERIOD = 65536;
  localparam int DECAY_W = $clog2(DECAY_PERIOD);
endpackage

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: synchronous frame FIFO with flush; a pop frees the slot for a same-cycle push
module audio_frame_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign valid = cnt_q != '0;
  assign full = cnt_q == FULL_CNT;
  assign rdata = mem_q[rd_q];
  // pointer and occupancy update; flush wins over everything
  always_comb begin
    do_pop = pop && valid && !flush;
    do_push = push && !flush && (!full || do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // frame storage; contents are only observed through valid, so no reset
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/audio_stream_router.sv
// audio_stream_router: source select, frame assembly, FIFO and handshake; AUDIO_ROUTER_PEAK_EN adds a per-channel peak meter
module audio_stream_router
  import audio_router_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SEL_W = $clog2(NUM_SRC)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic [SEL_W-1:0]                 select,
  input  logic                             mute,
  input  logic [NUM_SRC*NUM_CH-1:0]        src_valid,
  input  logic [NUM_SRC*NUM_CH*DATA_W-1:0] src_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH*DATA_W-1:0]         out_data,
  output logic [7:0]                       overflow_cnt,
  output logic                             realign,
  output logic [NUM_CH*PEAK_W-1:0]         peak_out
);
  state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NUM_CH-1:0] mask_q, mask_d, hit;
  logic [NUM_CH*DATA_W-1:0] stage_q, stage_d, frame, fifo_rdata;
  logic [7:0] ovf_q, ovf_d;
  logic realign_q, realign_d;
  logic flush, active, complete, pop, fifo_valid, fifo_full;
  assign hit = active ? src_valid[int'(sel_q)*NUM_CH +: NUM_CH] : '0;
  assign pop = out_valid && out_ready;
  assign out_data = (out_valid && !mute) ? fifo_rdata : '0;
  assign overflow_cnt = ovf_q;
  assign realign = realign_q;
  // state register
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  // next state: run low forces IDLE, a select change forces a one-cycle FLUSH
  always_comb begin
    state_d = !run ? IDLE : state_q == IDLE ? FLUSH : state_q == FLUSH ? COLLECT :
              select != sel_q ? FLUSH : COLLECT;
  end
  // state outputs: clear everything outside COLLECT, capture only while the select is stable
  always_comb begin
    flush = state_q != COLLECT;
    active = state_q == COLLECT && run && select == sel_q && int'(sel_q) < NUM_SRC;
    out_valid = state_q == COLLECT && fifo_valid;
  end
  // frame assembly, realign detection and overflow accounting
  always_comb begin
    frame = stage_q;
    for (int c = 0; c < NUM_CH; c++)
      if (hit[c]) frame[c*DATA_W +: DATA_W] = src_data[(int'(sel_q)*NUM_CH + c)*DATA_W +: DATA_W];
    complete = active && ((mask_q | hit) == '1);
    mask_d = (flush || complete) ? '0 : mask_q | hit;
    stage_d = flush ? '0 : frame;
    sel_d = state_q == FLUSH ? select : sel_q;
    realign_d = realign_q | (|(mask_q & hit));
    ovf_d = (complete && fifo_full && !pop && ovf_q != 8'hff) ? ovf_q + 8'd1 : ovf_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      mask_q <= '0;
      stage_q <= '0;
      ovf_q <= '0;
      realign_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      mask_q <= mask_d;
      stage_q <= stage_d;
      ovf_q <= ovf_d;
      realign_q <= realign_d;
    end
  end
  audio_frame_fifo #(.W(NUM_CH*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(complete),
    .pop(pop),
    .wdata(frame),
    .rdata(fifo_rdata),
    .valid(fifo_valid),
    .full(fifo_full)
  );
`ifdef AUDIO_ROUTER_PEAK_EN
  logic [NUM_CH*PEAK_W-1:0] peak_q, peak_d;
  logic [DECAY_W-1:0] tick_q, tick_d;
  logic [DATA_W-1:0] samp, mag;
  logic [PEAK_W-1:0] lvl, cur;
  assign peak_out = peak_q;
  // peak hold on emitted samples with slow decay; the most negative sample saturates
  always_comb begin
    tick_d = flush ? '0 : tick_q + DECAY_W'(1);
    peak_d = peak_q;
    samp = '0;
    mag = '0;
    lvl = '0;
    cur = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      samp = out_data[c*DATA_W +: DATA_W];
      mag = samp[DATA_W-1] ? -samp : samp;
      lvl = mag[DATA_W-1] ? '1 : mag[DATA_W-2 -: PEAK_W];
      cur = peak_q[c*PEAK_W +: PEAK_W];
      peak_d[c*PEAK_W +: PEAK_W] = flush ? '0 : (pop && lvl > cur) ? lvl :
                                   (tick_q == '1 && cur != '0) ? cur - PEAK_W'(1) : cur;
    end
  end
  // peak and decay-timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
      tick_q <= '0;
    end else begin
      peak_q <= peak_d;
      tick_q <= tick_d;
    end
  end
`else
  assign peak_out = '0;
`endif
endmodule

// File: tb/tb_audio_stream_router.sv
// tb_audio_stream_router: directed test-plan scenarios plus randomized traffic against a queue-based frame model
module tb_audio_stream_router;
  localparam int NS = 4, NC = 2, DW = 24, FD = 4, SW = 2, FW = NC * DW;
  logic clk = 0, reset = 1, run = 0, mute = 0, out_ready = 0;
  logic [SW-1:0] select = '0;
  logic [NS*NC-1:0] src_valid = '0;
  logic [NS*NC*DW-1:0] src_data = '0;
  logic out_valid, realign;
  logic [FW-1:0] out_data;
  logic [7:0] overflow_cnt;
  logic [NC*8-1:0] peak_out;
  int total = 0, bad = 0;
  int m_phase = 0;
  logic [SW-1:0] m_sel = '0;
  logic [NC-1:0] m_got = '0;
  logic [FW-1:0] m_stg = '0;
  logic [FW-1:0] m_q[$];
  int m_ovf = 0;
  logic m_rea = 0;

  audio_stream_router #(.NUM_SRC(NS), .NUM_CH(NC), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .run(run), .select(select), .mute(mute),
    .src_valid(src_valid), .src_data(src_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .overflow_cnt(overflow_cnt),
    .realign(realign), .peak_out(peak_out)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(int s, logic [NC-1:0] m, logic [DW-1:0] d0, logic [DW-1:0] d1);
    src_valid = '0;
    src_valid[s*NC +: NC] = m;
    src_data[(s*NC)*DW +: DW] = d0;
    src_data[(s*NC+1)*DW +: DW] = d1;
  endtask

  // Frame-level model: phase 0 idle, 1 flush, 2 collect; frames live in a bounded queue
  always @(posedge clk) begin
    int old;
    if (reset) begin
      m_phase = 0; m_sel = '0; m_got = '0; m_stg = '0; m_q.delete(); m_ovf = 0; m_rea = 0;
    end else begin
      old = m_phase;
      if (old == 2 && m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (old == 2 && run && select == m_sel) begin
        for (int c = 0; c < NC; c++)
          if (src_valid[int'(m_sel)*NC + c]) begin
            if (m_got[c]) m_rea = 1;
            m_got[c] = 1;
            m_stg[c*DW +: DW] = src_data[(int'(m_sel)*NC + c)*DW +: DW];
          end
        if (&m_got) begin
          if (m_q.size() < FD) m_q.push_back(m_stg);
          else if (m_ovf < 255) m_ovf++;
          m_got = '0;
        end
      end
      if (old != 2) begin m_q.delete(); m_got = '0; m_stg = '0; end
      m_phase = !run ? 0 : old == 0 ? 1 : old == 1 ? 2 : (select != m_sel) ? 1 : 2;
      if (old == 1) m_sel = select;
    end
  end

  // Every-cycle comparison of the DUT against the model, mid-cycle
  always @(negedge clk) begin
    logic ev;
    logic [FW-1:0] ed;
    ev = m_phase == 2 && m_q.size() > 0;
    ed = (ev && !mute) ? m_q[0] : '0;
    check("out_valid", out_valid, ev);
    check("out_data", out_data, ed);
    check("overflow_cnt", overflow_cnt, m_ovf);
    check("realign", realign, m_rea);
`ifndef AUDIO_ROUTER_PEAK_EN
    check("peak_off", peak_out, 0);
`endif
  end

  initial begin
    int rdy;
    repeat (2) cyc();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow_cnt, 0);
    check("rst_realign", realign, 0);
    check("rst_peak", peak_out, 0);
    reset = 0; run = 1; select = 2; out_ready = 1;
    repeat (3) cyc();
    // basic L then R on source 2; other sources ignored
    set_src(2, 2'b01, 24'h123456, 24'h0); cyc();
    set_src(2, 2'b10, 24'h0, 24'hABCDEF); cyc();
    src_valid = '0;
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, {24'hABCDEF, 24'h123456});
    set_src(0, 2'b11, 24'h1, 24'h2); cyc();
    set_src(1, 2'b11, 24'h3, 24'h4); cyc();
    set_src(3, 2'b11, 24'h5, 24'h6); cyc();
    src_valid = '0; cyc();
    check("t1_others", out_valid, 0);
    // back-pressure and overflow
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      set_src(2, 2'b11, 24'h100000 + DW'(i), 24'h200000 + DW'(i)); cyc();
    end
    src_valid = '0;
    check("t2_ovf", overflow_cnt, 2);
    check("t2_valid", out_valid, 1);
    repeat (3) begin
      check("t2_stall", out_data, {24'h200000, 24'h100000});
      cyc();
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", out_data, {24'h200000 + DW'(i), 24'h100000 + DW'(i)});
      cyc();
    end
    check("t2_drain", out_valid, 0);
    // realign: L, L, R
    set_src(2, 2'b01, 24'h111111, 24'h0); cyc();
    set_src(2, 2'b01, 24'h222222, 24'h0); cyc();
    check("t3_realign", realign, 1);
    set_src(2, 2'b10, 24'h0, 24'h333333); cyc();
    src_valid = '0;
    check("t3_data", out_data, {24'h333333, 24'h222222});
    // half frame then select switch
    select = 0; repeat (3) cyc();
    set_src(0, 2'b01, 24'h0AAAAA, 24'h0); cyc();
    src_valid = '0; select = 1; repeat (3) cyc();
    check("t4_nohalf", out_valid, 0);
    set_src(1, 2'b11, 24'h0C0C0C, 24'h0D0D0D); cyc();
    src_valid = '0;
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, {24'h0D0D0D, 24'h0C0C0C});
    cyc();
    // mute, then run drop
    mute = 1;
    set_src(1, 2'b11, 24'h777777, 24'h888888); cyc();
    src_valid = '0;
    check("t5_mvalid", out_valid, 1);
    check("t5_mdata", out_data, 0);
    out_ready = 0;
    set_src(1, 2'b11, 24'h999999, 24'h666666); cyc();
    src_valid = '0; run = 0; cyc();
    check("t5_runoff", out_valid, 0);
    check("t5_ovf_kept", overflow_cnt, 2);
    mute = 0; run = 1; repeat (3) cyc();
    // randomized traffic
    rdy = 3;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 99) == 0) rdy = $urandom_range(0, 4);
      for (int b = 0; b < NS * NC; b++) src_valid[b] = $urandom_range(0, 3) == 0;
      for (int k = 0; k < NS * NC * DW / 32; k++) src_data[k*32 +: 32] = $urandom();
      out_ready = $urandom_range(0, 3) < rdy;
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if ($urandom_range(0, 79) == 0) select = SW'($urandom_range(0, 3));
      run = run ? $urandom_range(0, 299) != 0 : $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 999) == 0;
      cyc();
    end
    reset = 0; src_valid = '0; mute = 0;
    // overflow saturation
    reset = 1; cyc(); reset = 0; run = 1; select = 0; out_ready = 0;
    repeat (3) cyc();
    for (int i = 0; i < 262; i++) begin
      set_src(0, 2'b11, DW'(i), DW'(i)); cyc();
    end
    src_valid = '0;
    check("sat_ovf", overflow_cnt, 255);
`ifdef AUDIO_ROUTER_PEAK_EN
    reset = 1; cyc(); reset = 0; out_ready = 1;
    repeat (3) cyc();
    set_src(0, 2'b11, 24'h400000, 24'h0); cyc();
    src_valid = '0; cyc();
    check("peak_hit", peak_out[7:0], 8'h80);
    repeat (65536) cyc();
    check("peak_decay", peak_out[7:0], 8'h7F);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
